// File: rtl/dafx_gain_ramp_scheduler_if.sv
// ---------------------------------------------------------------------------
// dafx_gain_ramp_scheduler_if
// Purpose : groups the register-file targets, the sample strobe and the
//           mixer-facing current gains of the gain ramp scheduler.
// Signals : sample_tick       one-cycle strobe per audio sample
//           cr_ramp_enable    1 = slew toward target, 0 = snap on tick
//           cr_ramp_step      per-tick step magnitude (all slots)
//           cr_channel_gain   per-channel target gains
//           cr_output_gain    output target gain
//           mix_channel_gain  current channel gains to the mixer
//           mix_output_gain   current output gain to the mixer
//           ramp_busy         some slot still differs from its target
//           sr_tick_overrun   sticky lost-tick flag
//           irq_ramp_done / cr_clear_ramp_irq  (only with DAFX_GAIN_RAMP_IRQ_EN)
// Handshake: there is no valid/ready pair on this bus. sample_tick is a
//           single-cycle strobe that is always accepted; a tick arriving while
//           a sweep runs is queued once (pending) and any further tick before
//           service is dropped and flagged in sr_tick_overrun. cr_* are level
//           registers sampled whenever the sequencer needs them.
// Master  : register file / sample timing side. Slave: the scheduler.
// ---------------------------------------------------------------------------
interface dafx_gain_ramp_scheduler_if #(
   parameter int NR_OF_CHANNELS_P = 3,
   parameter int GAIN_WIDTH_P     = 16,
   parameter int STEP_WIDTH_P     = 16
);
   logic                                         sample_tick;
   logic                                         cr_ramp_enable;
   logic [STEP_WIDTH_P-1:0]                      cr_ramp_step;
   logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] cr_channel_gain;
   logic [GAIN_WIDTH_P-1:0]                      cr_output_gain;
   logic [NR_OF_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] mix_channel_gain;
   logic [GAIN_WIDTH_P-1:0]                      mix_output_gain;
   logic                                         ramp_busy;
   logic                                         sr_tick_overrun;
`ifdef DAFX_GAIN_RAMP_IRQ_EN
   logic                                         irq_ramp_done;
   logic                                         cr_clear_ramp_irq;
`endif

   modport master (
      output sample_tick, cr_ramp_enable, cr_ramp_step, cr_channel_gain, cr_output_gain,
`ifdef DAFX_GAIN_RAMP_IRQ_EN
      output cr_clear_ramp_irq,
      input  irq_ramp_done,
`endif
      input  mix_channel_gain, mix_output_gain, ramp_busy, sr_tick_overrun
   );

   modport slave (
      input  sample_tick, cr_ramp_enable, cr_ramp_step, cr_channel_gain, cr_output_gain,
`ifdef DAFX_GAIN_RAMP_IRQ_EN
      input  cr_clear_ramp_irq,
      output irq_ramp_done,
`endif
      output mix_channel_gain, mix_output_gain, ramp_busy, sr_tick_overrun
   );
endinterface

// File: rtl/dafx_gain_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// dafx_gain_ramp_scheduler
// Purpose : slews the channel gains and the output gain toward their register
//           targets, one step per audio sample, using one shared add/clamp
//           unit time-multiplexed over NR_OF_CHANNELS_P+1 slots
//           (slot NR_OF_CHANNELS_P is the output gain).
// Ports   : clk, rst (async, active-high)
//           bus          slave modport of dafx_gain_ramp_scheduler_if
//           dbg_state_o  FSM state (0 IDLE, 1 SWEEP, 2 DONE)
//           dbg_idx_o    slot index currently being updated
// Option  : DAFX_GAIN_RAMP_IRQ_EN adds irq_ramp_done / cr_clear_ramp_irq.
// ---------------------------------------------------------------------------
module dafx_gain_ramp_scheduler #(
   parameter int NR_OF_CHANNELS_P = 3,
   parameter int GAIN_WIDTH_P     = 16,
   parameter int STEP_WIDTH_P     = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   dafx_gain_ramp_scheduler_if.slave             bus,
   output logic [1:0]                            dbg_state_o,
   output logic [$clog2(NR_OF_CHANNELS_P+1)-1:0] dbg_idx_o
);
   localparam int NS    = NR_OF_CHANNELS_P + 1;
   localparam int IDX_W = $clog2(NS);
   localparam int GW    = GAIN_WIDTH_P;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SWEEP = 2'd1, ST_DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             pending_q, pending_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic [GW-1:0]    gain_q [NS];
   logic [GW-1:0]    gain_d [NS];
   logic [GW-1:0]    tgt_all [NS];

   logic [GW-1:0]        cur, tgt, slot_next;
   logic signed [GW:0]   diff;
   logic [GW:0]          mag, step_ext, sum;
   logic                 any_diff;

`ifdef DAFX_GAIN_RAMP_IRQ_EN
   logic irq_q, irq_d;
`endif

   // Shared add/clamp unit working on the slot selected by idx_q.
   always_comb begin
      for (int k = 0; k < NR_OF_CHANNELS_P; k++) tgt_all[k] = bus.cr_channel_gain[k];
      tgt_all[NR_OF_CHANNELS_P] = bus.cr_output_gain;
      cur      = gain_q[idx_q];
      tgt      = tgt_all[idx_q];
      // One extra bit keeps target - current free of overflow.
      diff     = $signed({tgt[GW-1], tgt}) - $signed({cur[GW-1], cur});
      mag      = diff[GW] ? (GW+1)'(-diff) : (GW+1)'(diff);
      step_ext = (GW+1)'(bus.cr_ramp_step);
      sum      = diff[GW] ? ({cur[GW-1], cur} - step_ext) : ({cur[GW-1], cur} + step_ext);
      if (!bus.cr_ramp_enable || (mag <= step_ext)) slot_next = tgt;
      else                                        slot_next = sum[GW-1:0];
   end

   // Busy is judged on the fully updated values against live targets.
   always_comb begin
      any_diff = 1'b0;
      for (int k = 0; k < NS; k++) begin
         if (gain_q[k] != tgt_all[k]) any_diff = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      busy_d    = busy_q;
      gain_d    = gain_q;
`ifdef DAFX_GAIN_RAMP_IRQ_EN
      irq_d     = irq_q;
      if (bus.cr_clear_ramp_irq) irq_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.sample_tick || pending_q) begin
               state_d   = ST_SWEEP;
               idx_d     = '0;
               // A tick arriving while the pending flag is consumed re-arms it.
               pending_d = bus.sample_tick && pending_q;
            end
         end
         ST_SWEEP: begin
            gain_d[idx_q] = slot_next;
            if (idx_q == IDX_W'(NR_OF_CHANNELS_P)) state_d = ST_DONE;
            else                                   idx_d   = idx_q + IDX_W'(1);
         end
         ST_DONE: begin
            busy_d  = any_diff;
            state_d = ST_IDLE;
`ifdef DAFX_GAIN_RAMP_IRQ_EN
            // Set overrides a simultaneous clear.
            if (busy_q && !any_diff) irq_d = 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      if (bus.sample_tick && (state_q != ST_IDLE)) begin
         if (!pending_q) pending_d = 1'b1;
         else            overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
         for (int k = 0; k < NS; k++) gain_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
         gain_q    <= gain_d;
      end
   end

`ifdef DAFX_GAIN_RAMP_IRQ_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end
   assign bus.irq_ramp_done = irq_q;
`endif

   always_comb begin
      for (int k = 0; k < NR_OF_CHANNELS_P; k++) bus.mix_channel_gain[k] = gain_q[k];
   end
   assign bus.mix_output_gain = gain_q[NR_OF_CHANNELS_P];
   assign bus.ramp_busy       = busy_q;
   assign bus.sr_tick_overrun = overrun_q;
   assign dbg_state_o         = state_q;
   assign dbg_idx_o           = idx_q;
endmodule

// File: tb/tb_dafx_gain_ramp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dafx_gain_ramp_scheduler
// Self-checking bench for dafx_gain_ramp_scheduler (N=3, 16-bit gains/steps).
// Honours DAFX_GAIN_RAMP_IRQ_EN when defined.
// ---------------------------------------------------------------------------
module tb_dafx_gain_ramp_scheduler;
   localparam int N  = 3;
   localparam int GW = 16;
   localparam int SW = 16;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   logic [1:0] dbg_idx;

   dafx_gain_ramp_scheduler_if #(.NR_OF_CHANNELS_P(N), .GAIN_WIDTH_P(GW), .STEP_WIDTH_P(SW)) bus ();

   dafx_gain_ramp_scheduler #(.NR_OF_CHANNELS_P(N), .GAIN_WIDTH_P(GW), .STEP_WIDTH_P(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state),
      .dbg_idx_o   (dbg_idx)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int done_cnt = 0;
   always @(negedge clk) if (dbg_state == 2'd2) done_cnt = done_cnt + 1;

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [GW-1:0] exp_q[$];
   logic          exp_busy_q[$];
   logic [GW-1:0] tgt [N+1];
   logic [GW-1:0] exp_gain [N+1];
   logic          exp_busy;
   logic          en;
   logic [SW-1:0] step;

   typedef struct {
      logic          en;
      logic [SW-1:0] step;
      int            slot;
      logic [GW-1:0] tgt;
      logic [GW-1:0] exp_val;
      logic          exp_busy;
   } vec_t;
   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [GW-1:0] dut_gain(input int s);
      if (s == N) return bus.mix_output_gain;
      return bus.mix_channel_gain[s];
   endfunction

   task automatic drive_cr();
      bus.cr_ramp_enable = en;
      bus.cr_ramp_step   = step;
      for (int k = 0; k < N; k++) bus.cr_channel_gain[k] = tgt[k];
      bus.cr_output_gain = tgt[N];
   endtask

   task automatic check_all(input string name);
      for (int k = 0; k <= N; k++) check($sformatf("%s_slot%0d", name, k), 32'(dut_gain(k)), 32'(exp_gain[k]));
   endtask

   // Push expectations, pulse one tick, wait for the sweep, then pop/compare.
   task automatic run_tick(input string name);
      logic [GW-1:0] e;
      logic          eb;
      bit            seen;
      for (int k = 0; k <= N; k++) exp_q.push_back(exp_gain[k]);
      exp_busy_q.push_back(exp_busy);
      drive_cr();
      bus.sample_tick = 1'b1;
      @(negedge clk);
      bus.sample_tick = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (dbg_state == 2'd2) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      @(negedge clk);
      for (int k = 0; k <= N; k++) begin
         e = exp_q.pop_front();
         check($sformatf("%s_slot%0d", name, k), 32'(dut_gain(k)), 32'(e));
      end
      eb = exp_busy_q.pop_front();
      check({name, "_busy"}, 32'(bus.ramp_busy), 32'(eb));
   endtask

   function automatic vec_t mk(input logic e, input logic [SW-1:0] s, input int sl,
                               input logic [GW-1:0] t, input logic [GW-1:0] x, input logic b);
      vec_t v;
      v.en = e; v.step = s; v.slot = sl; v.tgt = t; v.exp_val = x; v.exp_busy = b;
      return v;
   endfunction

   initial begin
      int d0;
      vecs[0] = mk(1'b1, 16'h0100, 1, 16'hFF80, 16'hFF80, 1'b0); // negative target, no overshoot
      vecs[1] = mk(1'b0, 16'h0100, 3, 16'h7FFF, 16'h7FFF, 1'b0); // snap output gain
      vecs[2] = mk(1'b1, 16'h0000, 2, 16'h0300, 16'h0000, 1'b1); // step 0 holds
      vecs[3] = mk(1'b1, 16'h0100, 2, 16'h0250, 16'h0100, 1'b1);
      vecs[4] = mk(1'b1, 16'h0100, 2, 16'h0250, 16'h0200, 1'b1);
      vecs[5] = mk(1'b1, 16'h0100, 2, 16'h0250, 16'h0250, 1'b0); // final partial step clamps
      vecs[6] = mk(1'b0, 16'h0100, 0, 16'h8000, 16'h8000, 1'b0); // set up most negative
      vecs[7] = mk(1'b1, 16'hFFFF, 0, 16'h7FFF, 16'h7FFF, 1'b0); // full-scale swing, no wrap
      vecs[8] = mk(1'b1, 16'h0100, 3, 16'h7F80, 16'h7F80, 1'b0); // small downward diff
      vecs[9] = mk(1'b1, 16'h0010, 1, 16'h0000, 16'hFF90, 1'b1); // upward from negative

      rst = 1'b1;
      en = 1'b1;
      step = '0;
      for (int k = 0; k <= N; k++) begin tgt[k] = '0; exp_gain[k] = '0; end
      exp_busy = 1'b0;
      bus.sample_tick = 1'b0;
`ifdef DAFX_GAIN_RAMP_IRQ_EN
      bus.cr_clear_ramp_irq = 1'b0;
`endif
      drive_cr();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // ---- reset state ----
      check_all("reset");
      check("reset_busy", 32'(bus.ramp_busy), 32'd0);
      check("reset_overrun", 32'(bus.sr_tick_overrun), 32'd0);
      check("reset_state", 32'(dbg_state), 32'd0);
      check("reset_idx", 32'(dbg_idx), 32'd0);
`ifdef DAFX_GAIN_RAMP_IRQ_EN
      check("reset_irq", 32'(bus.irq_ramp_done), 32'd0);
`endif

      // ---- ramp up ch0 to 0x1000 in 16 steps of 0x100 ----
      en = 1'b1; step = 16'h0100; tgt[0] = 16'h1000;
      for (int t = 1; t <= 16; t++) begin
         exp_gain[0] = 16'(t * 16'h0100);
         exp_busy    = (t < 16);
         run_tick($sformatf("ramp%0d", t));
`ifdef DAFX_GAIN_RAMP_IRQ_EN
         check($sformatf("ramp%0d_irq", t), 32'(bus.irq_ramp_done), 32'(t == 16));
`endif
      end
`ifdef DAFX_GAIN_RAMP_IRQ_EN
      bus.cr_clear_ramp_irq = 1'b1;
      @(negedge clk);
      bus.cr_clear_ramp_irq = 1'b0;
      @(negedge clk);
      check("irq_cleared", 32'(bus.irq_ramp_done), 32'd0);
`endif

      // ---- table-driven vectors ----
      foreach (vecs[i]) begin
         en = vecs[i].en; step = vecs[i].step;
         tgt[vecs[i].slot]      = vecs[i].tgt;
         exp_gain[vecs[i].slot] = vecs[i].exp_val;
         exp_busy               = vecs[i].exp_busy;
         run_tick($sformatf("vec%0d", i));
      end

      // ---- snap latency: output gain lands 4 cycles after the tick ----
      en = 1'b0; tgt[3] = 16'h1234; drive_cr();
      bus.sample_tick = 1'b1;
      @(negedge clk);
      bus.sample_tick = 1'b0;
      repeat (3) @(negedge clk);
      check("snap_lat3_old", 32'(bus.mix_output_gain), 32'h7F80);
      @(negedge clk);
      check("snap_lat4_new", 32'(bus.mix_output_gain), 32'h1234);
      repeat (4) @(negedge clk);
      exp_gain[1] = 16'h0000; exp_gain[3] = 16'h1234;
      check_all("snap_final");
      check("snap_busy", 32'(bus.ramp_busy), 32'd0);

      // ---- two ticks inside one sweep: queued, no overrun ----
      en = 1'b1; step = 16'h0010; tgt[0] = 16'h7FFF - 16'h0100; drive_cr();
      // ch0 currently 0x7FFF; walk down by 0x10 per sweep
      d0 = done_cnt;
      bus.sample_tick = 1'b1; @(negedge clk);
      bus.sample_tick = 1'b0; @(negedge clk);
      bus.sample_tick = 1'b1; @(negedge clk);
      bus.sample_tick = 1'b0;
      repeat (20) @(negedge clk);
      check("pend_sweeps", 32'(done_cnt - d0), 32'd2);
      check("pend_ch0", 32'(bus.mix_channel_gain[0]), 32'h7FDF);
      check("pend_overrun", 32'(bus.sr_tick_overrun), 32'd0);

      // ---- three ticks inside one sweep: one dropped ----
      d0 = done_cnt;
      bus.sample_tick = 1'b1; @(negedge clk);
      bus.sample_tick = 1'b0; @(negedge clk);
      bus.sample_tick = 1'b1; @(negedge clk);
      bus.sample_tick = 1'b1; @(negedge clk);
      bus.sample_tick = 1'b0;
      repeat (20) @(negedge clk);
      check("ovr_sweeps", 32'(done_cnt - d0), 32'd2);
      check("ovr_ch0", 32'(bus.mix_channel_gain[0]), 32'h7FBF);
      check("ovr_overrun", 32'(bus.sr_tick_overrun), 32'd1);
      check("ovr_busy", 32'(bus.ramp_busy), 32'd1);

      // ---- reset in the middle of a sweep ----
      en = 1'b0; drive_cr();
      bus.sample_tick = 1'b1; @(negedge clk);
      bus.sample_tick = 1'b0; @(negedge clk);
      check("mid_idx", 32'(dbg_idx), 32'd1);
      check("mid_state", 32'(dbg_state), 32'd1);
      rst = 1'b1;
      #1;
      for (int k = 0; k <= N; k++) exp_gain[k] = '0;
      check_all("midrst");
      check("midrst_state", 32'(dbg_state), 32'd0);
      check("midrst_idx", 32'(dbg_idx), 32'd0);
      check("midrst_busy", 32'(bus.ramp_busy), 32'd0);
      check("midrst_overrun", 32'(bus.sr_tick_overrun), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("postrst_state", 32'(dbg_state), 32'd0);
      for (int k = 0; k <= N; k++) exp_gain[k] = tgt[k];
      exp_busy = 1'b0;
      run_tick("postrst");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
